rvtest_monitor: RTL and testbench
=================================

// Module: rvtest_monitor
//
// PURPOSE
//   Consumes the core data-bus store stream in the RISC-V compliance bench and decides the test verdict.
//   Watches for the riscv-tests "tohost" exit store, then latches PASS, FAIL or TIMEOUT.
//   Instantiated next to top in each rvtests bench; the bench waits on done, then checks pass.
//   Replaces fixed-iteration run loops with a deterministic end-of-test condition.
//
// PARAMETERS
//   TOHOST_ADDR      32'h0000_1000  byte address of the tohost exit word
//   WATCHDOG_CYCLES  100000         cycles allowed in RUN before TIMEOUT (>=2)
//   CNT_W            32             width of cycle_count
//
// PORTS
//   sys_clk      in   1      clock, all logic on rising edge
//   sys_res      in   1      synchronous reset, active-high
//   mem_we       in   1      core data-memory write enable (one store per asserted cycle)
//   mem_addr     in   32     core data-memory byte address
//   mem_wdata    in   32     core data-memory write data
//   done         out  1      verdict reached (PASS, FAIL or TIMEOUT), sticky
//   pass         out  1      tohost written with 1
//   fail         out  1      tohost written with odd value other than 1
//   timeout      out  1      watchdog expired before any exit store
//   fail_test    out  31     failing test number = mem_wdata[31:1] of exit store
//   cycle_count  out  CNT_W  cycles spent in RUN, frozen once done
//
// BEHAVIOUR
//   - Reset (sys_res=1 at edge): state=RUN; done, pass, fail, timeout = 0; fail_test = 0; cycle_count = 0.
//   - FSM states: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and left only by reset.
//   - Exit store: mem_we=1, mem_addr==TOHOST_ADDR (full 32-bit compare) and mem_wdata[0]==1.
//     - mem_wdata==1: RUN->PASS.
//     - Otherwise: RUN->FAIL, fail_test <= mem_wdata[31:1].
//   - Stores to TOHOST_ADDR with mem_wdata[0]==0 are ignored; stores to any other address are ignored.
//   - Latency: outputs are registered and take their new value at the edge that samples the exit store;
//     the bench sees them one cycle after driving the store.
//   - cycle_count increments by 1 each cycle in RUN. It saturates at all-ones if CNT_W is too narrow; it never wraps.
//   - Watchdog: in RUN, when cycle_count == WATCHDOG_CYCLES-1 and there is no exit store this cycle: RUN->TIMEOUT.
//   - Simultaneous exit store and watchdog expiry: the store wins (PASS or FAIL).
//   - Terminal states ignore all further stores; fail_test and cycle_count hold.
//   - done = pass|fail|timeout. Exactly one of pass/fail/timeout is high when done=1.
//   - Reset mid-run or after a verdict clears everything at the next edge. Reset overrides a same-cycle exit store.
//
// CONFIGURATION
//   RVTEST_MONITOR_TRACE_EN defined:
//     - Simulation-only $display on entry to each terminal state, printing verdict, fail_test and cycle_count.
//     - $display on every ignored store to TOHOST_ADDR.
//   Not defined:
//     - No display code compiled.
//     - Ports, state and timing are identical in both configurations.
//
// TESTING
//   1. Reset, then store 32'h1 to TOHOST_ADDR at cycle 10 -> next cycle done=1, pass=1, fail=0,
//      cycle_count=10 (held constant afterwards).
//   2. Store 32'h0000_0007 to TOHOST_ADDR -> fail=1, fail_test=3, pass=0, timeout=0.
//   3. WATCHDOG_CYCLES=50 with no stores -> timeout=1 and done=1 after exactly 50 RUN cycles; cycle_count=49.
//   4. WATCHDOG_CYCLES=50 and store 32'h1 in the expiry cycle -> pass=1, timeout=0.
//   5. Store 32'h2 to TOHOST_ADDR, store 32'h1 to TOHOST_ADDR+4, then store 32'h5 to TOHOST_ADDR
//      -> first two ignored; fail=1, fail_test=2. A later store of 32'h1 leaves fail=1, pass=0.
//   6. After PASS assert sys_res for 1 cycle -> all outputs 0 at that edge; a new run counts from 0.

Source files
------------

// File: rtl/rvtest_monitor.sv
// End-of-test monitor for the RISC-V compliance bench: watches the tohost exit store
// and latches a PASS / FAIL / TIMEOUT verdict. Optional trace: RVTEST_MONITOR_TRACE_EN.
module rvtest_monitor #(
  parameter logic [31:0] TOHOST_ADDR     = 32'h0000_1000,
  parameter int unsigned WATCHDOG_CYCLES = 100000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             sys_clk,
  input  logic             sys_res,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [30:0]      fail_test,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [63:0] WD_LAST = 64'(WATCHDOG_CYCLES) - 64'd1;

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_e;

  state_e           state_q, state_d;
  logic             tohost_wr_c, exit_store_c, wd_expire_c, cnt_max_c;
  logic             done_q, pass_q, fail_q, timeout_q;
  logic             done_d, pass_d, fail_d, timeout_d;
  logic [30:0]      fail_test_q, fail_test_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tohost_wr_c  = mem_we && (mem_addr == TOHOST_ADDR);
  assign exit_store_c = tohost_wr_c && mem_wdata[0];
  // Widen both sides so a watchdog limit beyond the counter range simply never fires.
  assign wd_expire_c  = (64'(cnt_q) == WD_LAST);
  assign cnt_max_c    = &cnt_q;

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_res) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // Next-state logic: exit store has priority over watchdog expiry
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (exit_store_c) begin
        state_d = (mem_wdata == 32'd1) ? ST_PASS : ST_FAIL;
      end else if (wd_expire_c) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    pass_d      = (state_d == ST_PASS);
    fail_d      = (state_d == ST_FAIL);
    timeout_d   = (state_d == ST_TIMEOUT);
    done_d      = pass_d | fail_d | timeout_d;
    fail_test_d = fail_test_q;
    cnt_d       = cnt_q;
    if (state_q == ST_RUN && state_d == ST_RUN && !cnt_max_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (state_q == ST_RUN && state_d == ST_FAIL) begin
      fail_test_d = mem_wdata[31:1];
    end
  end

  // Output registers
  always_ff @(posedge sys_clk) begin
    if (sys_res) begin
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_test_q <= '0;
      cnt_q       <= '0;
    end else begin
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      fail_test_q <= fail_test_d;
      cnt_q       <= cnt_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign fail_test   = fail_test_q;
  assign cycle_count = cnt_q;

`ifdef RVTEST_MONITOR_TRACE_EN
  // Simulation trace of verdicts and ignored tohost stores
  always @(posedge sys_clk) begin
    if (!sys_res) begin
      if (state_q == ST_RUN && state_d != ST_RUN) begin
        $display("rvtest_monitor: verdict=%s fail_test=%0d cycle_count=%0d",
                 (state_d == ST_PASS) ? "pass" : (state_d == ST_FAIL) ? "fail" : "timeout",
                 fail_test_d, cnt_q);
      end
      if (tohost_wr_c && (state_q != ST_RUN || !mem_wdata[0])) begin
        $display("rvtest_monitor: ignored tohost store data=0x%08h", mem_wdata);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rvtest_monitor.sv
// Bench for rvtest_monitor: directed scenarios plus random store traffic, two instances
// (normal counter, and a narrow saturating counter) checked against a verdict model.
module tb_rvtest_monitor;

  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        res, we;
  logic [31:0] addr, wdata;

  logic        done0, pass0, fail0, tmo0;
  logic [30:0] ft0;
  logic [31:0] cc0;
  logic        done1, pass1, fail1, tmo1;
  logic [30:0] ft1;
  logic [3:0]  cc1;

  int errors = 0;
  int checks = 0;

  // Model state per instance: verdict 0=run 1=pass 2=fail 3=timeout
  int          m_verdict [2];
  longint      m_cnt     [2];
  logic [30:0] m_ft      [2];
  longint      m_wd      [2];
  longint      m_max     [2];

  always #5 clk = ~clk;

  rvtest_monitor #(.TOHOST_ADDR(TOHOST), .WATCHDOG_CYCLES(50), .CNT_W(32)) u_dut0 (
    .sys_clk(clk), .sys_res(res), .mem_we(we), .mem_addr(addr), .mem_wdata(wdata),
    .done(done0), .pass(pass0), .fail(fail0), .timeout(tmo0),
    .fail_test(ft0), .cycle_count(cc0)
  );

  rvtest_monitor #(.TOHOST_ADDR(TOHOST), .WATCHDOG_CYCLES(40), .CNT_W(4)) u_dut1 (
    .sys_clk(clk), .sys_res(res), .mem_we(we), .mem_addr(addr), .mem_wdata(wdata),
    .done(done1), .pass(pass1), .fail(fail1), .timeout(tmo1),
    .fail_test(ft1), .cycle_count(cc1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of verdict rules applied to the model
  task automatic model_step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_verdict[i] = 0;
        m_cnt[i]     = 0;
        m_ft[i]      = '0;
      end else if (m_verdict[i] == 0) begin
        if (w && a == TOHOST && d[0]) begin
          if (d == 32'd1) m_verdict[i] = 1;
          else begin
            m_verdict[i] = 2;
            m_ft[i]      = d[31:1];
          end
        end else if (m_cnt[i] == m_wd[i] - 1) begin
          m_verdict[i] = 3;
        end else if (m_cnt[i] < m_max[i]) begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("done0",    64'(done0), 64'(m_verdict[0] != 0));
    check("pass0",    64'(pass0), 64'(m_verdict[0] == 1));
    check("fail0",    64'(fail0), 64'(m_verdict[0] == 2));
    check("timeout0", 64'(tmo0),  64'(m_verdict[0] == 3));
    check("ft0",      64'(ft0),   64'(m_ft[0]));
    check("cnt0",     64'(cc0),   64'(m_cnt[0]));
    check("done1",    64'(done1), 64'(m_verdict[1] != 0));
    check("pass1",    64'(pass1), 64'(m_verdict[1] == 1));
    check("fail1",    64'(fail1), 64'(m_verdict[1] == 2));
    check("timeout1", 64'(tmo1),  64'(m_verdict[1] == 3));
    check("ft1",      64'(ft1),   64'(m_ft[1]));
    check("cnt1",     64'(cc1),   64'(m_cnt[1]));
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    res = r; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    model_step(r, w, a, d);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    res = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    m_wd[0] = 50; m_max[0] = 64'hFFFF_FFFF;
    m_wd[1] = 40; m_max[1] = 15;
    for (int i = 0; i < 2; i++) begin
      m_verdict[i] = 0; m_cnt[i] = 0; m_ft[i] = '0;
    end

    // Reset state
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_cnt",  64'(cc0),   64'd0);

    // Pass at cycle 10, count then held
    idle(10);
    drive(1'b0, 1'b1, TOHOST, 32'h1);
    check("t1_pass", 64'(pass0), 64'd1);
    check("t1_cnt",  64'(cc0),   64'd10);
    idle(5);
    check("t1_hold", 64'(cc0),   64'd10);

    // Fail with test number 3
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, TOHOST, 32'h7);
    check("t2_fail", 64'(fail0), 64'd1);
    check("t2_ft",   64'(ft0),   64'd3);

    // Watchdog expiry after 50 RUN cycles; narrow instance saturates
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    idle(49);
    check("t3_pre", 64'(tmo0), 64'd0);
    idle(1);
    check("t3_tmo", 64'(tmo0), 64'd1);
    check("t3_cnt", 64'(cc0),  64'd49);
    check("t3_sat", 64'(cc1),  64'd15);

    // Store in the expiry cycle wins
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    idle(49);
    drive(1'b0, 1'b1, TOHOST, 32'h1);
    check("t4_pass", 64'(pass0), 64'd1);
    check("t4_tmo",  64'(tmo0),  64'd0);

    // Ignored stores, then fail, then late store ignored
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, TOHOST, 32'h2);
    drive(1'b0, 1'b1, TOHOST + 32'd4, 32'h1);
    check("t5_run", 64'(done0), 64'd0);
    drive(1'b0, 1'b1, TOHOST, 32'h5);
    drive(1'b0, 1'b1, TOHOST, 32'h1);
    check("t5_fail", 64'(fail0), 64'd1);
    check("t5_ft",   64'(ft0),   64'd2);
    check("t5_pass", 64'(pass0), 64'd0);

    // Reset after PASS, reset overriding a same-cycle exit store, recount from 0
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b1, TOHOST, 32'h1);
    drive(1'b1, 1'b1, TOHOST, 32'h1);
    check("t6_done", 64'(done0), 64'd0);
    idle(3);
    check("t6_cnt",  64'(cc0),   64'd3);

    // Random store traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      logic        r, w;
      logic [31:0] a, d;
      int unsigned sel;
      r = ($urandom_range(79) == 0);
      w = 1'($urandom_range(1));
      sel = $urandom_range(39);
      a = (sel == 0) ? TOHOST : (sel == 1) ? TOHOST + 32'd4 : $urandom;
      case ($urandom_range(3))
        0:       d = 32'h1;
        1:       d = $urandom | 32'h1;
        2:       d = $urandom & ~32'h1;
        default: d = $urandom;
      endcase
      drive(r, w, a, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
